// File: rtl/sparc_ifu_sscan_buf.sv
// Shadow-scan snapshot buffer: edge-triggered captures into a small FIFO, serial LSB-first readout.
// Optional SSCAN_TIMESTAMP_EN appends a 16-bit free-running cycle stamp to every stored entry.
module sparc_ifu_sscan_buf #(
  parameter int unsigned WIDTH = 94,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           rclk,
  input  logic                           arst_l,
  input  logic                           ctu_sscan_snap,
  input  logic [WIDTH-1:0]               snap_data,
  input  logic                           sscan_mode,
  input  logic                           sscan_shift_en,
  input  logic                           sscan_clr,
  output logic                           sparc_sscan_so,
  output logic                           sscan_so_vld,
  output logic [$clog2(DEPTH+1)-1:0]     sscan_cnt,
  output logic                           sscan_ovf
);

`ifdef SSCAN_TIMESTAMP_EN
  localparam int unsigned TS_W = 16;
`else
  localparam int unsigned TS_W = 0;
`endif
  localparam int unsigned EW = WIDTH + TS_W;
  localparam int unsigned BW = (EW > 1) ? $clog2(EW) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata;
  logic [EW-1:0] head;

  logic          snap_f;
  logic          armed;
  logic [PW-1:0] wr_ptr, wr_nxt;
  logic [PW-1:0] rd_ptr, rd_nxt;
  logic [BW-1:0] bit_idx, bit_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_nxt, so_nxt, vld_nxt, wr_en;
  logic          capture, shifting, last_bit, pop, full, accept;

`ifdef SSCAN_TIMESTAMP_EN
  logic [15:0] ts;

  // Free-running cycle stamp, wraps naturally at 16 bits
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) ts <= 16'd0;
    else         ts <= ts + 16'd1;
  end

  assign wdata = {ts, snap_data};
`else
  assign wdata = snap_data;
`endif

  // Entry storage is deliberately left out of reset
  always_ff @(posedge rclk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Next-state: shift/pop, capture policy when full, synchronous clear
  always_comb begin
    head     = mem[rd_ptr];
    // armed blocks the first post-reset cycle, since snap_f is not yet meaningful
    capture  = armed & ctu_sscan_snap & ~snap_f;
    shifting = sscan_shift_en & (sscan_cnt != '0);
    last_bit = (bit_idx == BW'(EW - 1));
    pop      = shifting & last_bit;
    full     = (sscan_cnt == CW'(DEPTH));
    accept   = capture & (~full | pop);

    wr_en    = 1'b0;
    wr_nxt   = wr_ptr;
    rd_nxt   = rd_ptr;
    bit_nxt  = bit_idx;
    cnt_nxt  = sscan_cnt;
    ovf_nxt  = sscan_ovf;
    so_nxt   = 1'b0;
    vld_nxt  = 1'b0;

    if (sscan_clr) begin
      wr_nxt  = '0;
      rd_nxt  = '0;
      bit_nxt = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else begin
      if (shifting) begin
        so_nxt  = head[bit_idx];
        vld_nxt = 1'b1;
        if (last_bit) begin
          bit_nxt = '0;
          rd_nxt  = rd_ptr + PW'(1);
        end else begin
          bit_nxt = bit_idx + BW'(1);
        end
      end

      if (accept) begin
        wr_en  = 1'b1;
        wr_nxt = wr_ptr + PW'(1);
      end else if (capture) begin
        ovf_nxt = 1'b1;
        // Overwrite only while the head is untouched; a head whose bit 0 leaves now is mid-readout
        if (sscan_mode && (bit_idx == '0) && !shifting) begin
          wr_en  = 1'b1;
          wr_nxt = wr_ptr + PW'(1);
          rd_nxt = rd_ptr + PW'(1);
        end
      end

      cnt_nxt = sscan_cnt + CW'(accept) - CW'(pop);
    end
  end

  // State and registered outputs
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      snap_f         <= 1'b0;
      armed          <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bit_idx        <= '0;
      sscan_cnt      <= '0;
      sscan_ovf      <= 1'b0;
      sparc_sscan_so <= 1'b0;
      sscan_so_vld   <= 1'b0;
    end else begin
      snap_f         <= ctu_sscan_snap;
      armed          <= 1'b1;
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      bit_idx        <= bit_nxt;
      sscan_cnt      <= cnt_nxt;
      sscan_ovf      <= ovf_nxt;
      sparc_sscan_so <= so_nxt;
      sscan_so_vld   <= vld_nxt;
    end
  end

endmodule
